ap_cmd_sequencer: RTL and testbench

//  Upstream driver of the AP/Data line. Takes one decoded Brainfuck data-side command (+ - > < or

---
 rtl/dpc_ap_pkg.sv | 41 ++++
 rtl/ap_cmd_sequencer.sv | 131 +++++++++++++
 tb/tb_ap_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dpc_ap_pkg.sv
// Shared definitions for the AP/Data line command path.
//   ap_cmd_t   : 3-bit data-side opcode (codes 6-7 are unused and act as NOP)
//   ap_state_t : command sequencer FSM states
//   REP_WIDTH_DEFAULT : default width of the run-length repeat count
// Helper functions classify an opcode as a step command, pointer vs data, and direction.
package dpc_ap_pkg;

  localparam int unsigned REP_WIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    CmdNop   = 3'd0,
    CmdInc   = 3'd1,
    CmdDec   = 3'd2,
    CmdRight = 3'd3,
    CmdLeft  = 3'd4,
    CmdTest  = 3'd5
  } ap_cmd_t;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StGuard = 3'd2,
    StWait  = 3'd3,
    StDone  = 3'd4
  } ap_state_t;

  // Commands that produce ApLine pulses.
  function automatic logic cmd_is_step(input ap_cmd_t cmd);
    return (cmd == CmdInc) || (cmd == CmdDec) || (cmd == CmdRight) || (cmd == CmdLeft);
  endfunction

  // Pointer commands use ApRequest, data commands use DataRequest.
  function automatic logic cmd_is_ap(input ap_cmd_t cmd);
    return (cmd == CmdRight) || (cmd == CmdLeft);
  endfunction

  function automatic logic cmd_is_dec(input ap_cmd_t cmd);
    return (cmd == CmdDec) || (cmd == CmdLeft);
  endfunction

endpackage

// File: rtl/ap_cmd_sequencer.sv
// ap_cmd_sequencer: upstream driver of the AP/Data line.
// Accepts one decoded data-side command with a run-length repeat count and turns it into
// ApLine request pulses, waiting for ApLine Ready after each one. Reports completion (Ready)
// and the DataZero result (DataIsZero) to the instruction sequencer.
//
// Optional feature macro: AP_BOUND_CHECK_EN
//   defined   : LEFT while ApZero=1 issues no pulse, sets sticky Fault and finishes the command.
//   undefined : Fault stays 0 and LEFT at address 0 is issued (ApLine wraps the pointer).
//
// Ports
//   Clk, Rst_n   clock; asynchronous active-low reset
//   Request      1-cycle command strobe, sampled only in IDLE with LineReady high
//   Insn         opcode (ap_cmd_t)
//   RepCount     repeat count; 0 = no-op
//   Ready        IDLE & ~Request & LineReady (combinational)
//   DataIsZero   DataZero captured when a command completes
//   Fault        sticky bound-check error flag
//   ApRequest    pointer step pulse to ApLine
//   DataRequest  data step pulse to ApLine
//   Dec          step direction, stable for the whole command
//   LineReady    ApLine Ready
//   DataZero     ApLine DataZero
//   ApZero       ApLine ApZero
module ap_cmd_sequencer
  import dpc_ap_pkg::*;
#(
  parameter int unsigned REP_WIDTH = REP_WIDTH_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Request,
  input  ap_cmd_t              Insn,
  input  logic [REP_WIDTH-1:0] RepCount,
  output logic                 Ready,
  output logic                 DataIsZero,
  output logic                 Fault,
  output logic                 ApRequest,
  output logic                 DataRequest,
  output logic                 Dec,
  input  logic                 LineReady,
  input  logic                 DataZero,
  input  logic                 ApZero
);

  ap_state_t            state_q;
  ap_cmd_t              cmd_q;
  logic [REP_WIDTH-1:0] rem_q;
  logic                 fault_q;
  logic                 left_blocked_idle;
  logic                 left_blocked_wait;

`ifdef AP_BOUND_CHECK_EN
  // Pointer already at 0: a further LEFT would underflow.
  assign left_blocked_idle = (Insn == CmdLeft) && ApZero;
  assign left_blocked_wait = (cmd_q == CmdLeft) && ApZero;
`else
  logic unused_ap_zero;
  assign unused_ap_zero    = ApZero;
  assign left_blocked_idle = 1'b0;
  assign left_blocked_wait = 1'b0;
`endif

  // Never set when the bound check is compiled out, so Fault is constant 0 there.
  assign Fault = fault_q;
  assign Ready = (state_q == StIdle) && !Request && LineReady;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= CmdNop;
      rem_q       <= '0;
      fault_q     <= 1'b0;
      ApRequest   <= 1'b0;
      DataRequest <= 1'b0;
      Dec         <= 1'b0;
      DataIsZero  <= 1'b0;
    end else begin
      // Request pulses last exactly one cycle (the ISSUE state).
      ApRequest   <= 1'b0;
      DataRequest <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Request && LineReady) begin
            cmd_q   <= Insn;
            rem_q   <= RepCount;
            Dec     <= cmd_is_dec(Insn);
            fault_q <= 1'b0;
            if (!cmd_is_step(Insn) || (RepCount == '0)) begin
              state_q <= StDone;
            end else if (left_blocked_idle) begin
              fault_q <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q     <= StIssue;
              ApRequest   <= cmd_is_ap(Insn);
              DataRequest <= !cmd_is_ap(Insn);
            end
          end
        end
        StIssue: begin
          if (rem_q != '0) begin
            rem_q <= rem_q - REP_WIDTH'(1);
          end
          state_q <= StGuard;
        end
        // ApLine only drops Ready one cycle after the pulse, so LineReady is not trusted here.
        StGuard: state_q <= StWait;
        StWait: begin
          if (LineReady) begin
            if (rem_q == '0) begin
              state_q <= StDone;
            end else if (left_blocked_wait) begin
              fault_q <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q     <= StIssue;
              ApRequest   <= cmd_is_ap(cmd_q);
              DataRequest <= !cmd_is_ap(cmd_q);
            end
          end
        end
        StDone: begin
          DataIsZero <= DataZero;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_cmd_sequencer.sv
// Directed bench for ap_cmd_sequencer with a small behavioural ApLine model
// (30000-cell tape, wrapping pointer, Ready low for two cycles after each pulse).
module tb_ap_cmd_sequencer;
  import dpc_ap_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Request = 1'b0;
  ap_cmd_t    Insn = CmdNop;
  logic [3:0] RepCount = 4'd0;
  logic       Ready, DataIsZero, Fault, ApRequest, DataRequest, Dec;
  logic       LineReady, DataZero, ApZero;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  ap_cmd_sequencer #(.REP_WIDTH(4)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Request    (Request),
    .Insn       (Insn),
    .RepCount   (RepCount),
    .Ready      (Ready),
    .DataIsZero (DataIsZero),
    .Fault      (Fault),
    .ApRequest  (ApRequest),
    .DataRequest(DataRequest),
    .Dec        (Dec),
    .LineReady  (LineReady),
    .DataZero   (DataZero),
    .ApZero     (ApZero)
  );

  // ApLine model
  logic [14:0] addr = 15'd0;
  logic [7:0]  mem [30000] = '{default: 8'd0};
  int          busy = 0;
  int          ap_cnt = 0;
  int          data_cnt = 0;
  logic        last_dec = 1'b0;
  logic        both_seen = 1'b0;

  assign LineReady = (busy == 0);
  assign DataZero  = (mem[addr] == 8'd0);
  assign ApZero    = (addr == 15'd0);

  always @(posedge Clk) begin
    if (ApRequest && DataRequest) both_seen <= 1'b1;
    if (ApRequest) begin
      ap_cnt   <= ap_cnt + 1;
      last_dec <= Dec;
      busy     <= 2;
      if (Dec) addr <= (addr == 15'd0) ? 15'd29999 : addr - 15'd1;
      else     addr <= (addr == 15'd29999) ? 15'd0 : addr + 15'd1;
    end else if (DataRequest) begin
      data_cnt  <= data_cnt + 1;
      last_dec  <= Dec;
      busy      <= 2;
      mem[addr] <= Dec ? mem[addr] - 8'd1 : mem[addr] + 8'd1;
    end else if (busy != 0) begin
      busy <= busy - 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (Ready !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (Ready !== 1'b1) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_pulse(input string tag);
    int n = 0;
    while (!(ApRequest || DataRequest) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!(ApRequest || DataRequest)) check({tag, "_pulse_timeout"}, 0, 1);
  endtask

  task automatic start_cmd(input ap_cmd_t c, input logic [3:0] n);
    @(negedge Clk);
    Request  = 1'b1;
    Insn     = c;
    RepCount = n;
    @(negedge Clk);
    Request  = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input ap_cmd_t c, input logic [3:0] n);
    wait_ready(tag);
    start_cmd(c, n);
    wait_ready(tag);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_aprequest", int'(ApRequest), 0);
    check("rst_datarequest", int'(DataRequest), 0);
    check("rst_dec", int'(Dec), 0);
    check("rst_dataiszero", int'(DataIsZero), 0);
    check("rst_fault", int'(Fault), 0);
    check("rst_ready", int'(Ready), 1);
    Rst_n = 1'b1;

    // INC x3 at address 0
    run_cmd("inc3", CmdInc, 4'd3);
    check("inc3_data_pulses", data_cnt, 3);
    check("inc3_ap_pulses", ap_cnt, 0);
    check("inc3_cell", int'(mem[0]), 3);
    check("inc3_dec", int'(last_dec), 0);
    check("inc3_dataiszero", int'(DataIsZero), 0);

    // RIGHT x5 then LEFT x2 -> address 3
    run_cmd("right5", CmdRight, 4'd5);
    check("right5_ap_pulses", ap_cnt, 5);
    check("right5_addr", int'(addr), 5);
    check("right5_dataiszero", int'(DataIsZero), 1);
    run_cmd("left2", CmdLeft, 4'd2);
    check("left2_ap_pulses", ap_cnt, 7);
    check("left2_addr", int'(addr), 3);
    check("left2_pulse_dec", int'(last_dec), 1);
    check("left2_dec_held", int'(Dec), 1);

    // TEST on a zero cell: two-cycle latency, no pulses
    wait_ready("test");
    start_cmd(CmdTest, 4'd0);
    check("test_busy", int'(Ready), 0);
    @(negedge Clk);
    check("test_ready_2cyc", int'(Ready), 1);
    check("test_dataiszero", int'(DataIsZero), 1);
    check("test_no_pulses", ap_cnt + data_cnt, 10);

    run_cmd("inc1", CmdInc, 4'd1);
    check("inc1_cell", int'(mem[3]), 1);
    check("inc1_dataiszero", int'(DataIsZero), 0);
    run_cmd("dec1", CmdDec, 4'd1);
    check("dec1_data_pulses", data_cnt, 5);
    check("dec1_pulse_dec", int'(last_dec), 1);
    run_cmd("test2", CmdTest, 4'd0);
    check("test2_dataiszero", int'(DataIsZero), 1);

    // Reset during WAIT of a LEFT x3
    wait_ready("rstmid");
    start_cmd(CmdLeft, 4'd3);
    wait_pulse("rstmid");
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("rstmid_aprequest", int'(ApRequest), 0);
    check("rstmid_datarequest", int'(DataRequest), 0);
    check("rstmid_dec", int'(Dec), 0);
    check("rstmid_dataiszero", int'(DataIsZero), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);
    check("rstmid_ap_pulses", ap_cnt, 8);
    check("rstmid_addr", int'(addr), 2);

    // INC with RepCount 0: no pulses, Ready after two cycles, DataIsZero refreshed
    wait_ready("inc0");
    start_cmd(CmdInc, 4'd0);
    check("inc0_busy", int'(Ready), 0);
    @(negedge Clk);
    check("inc0_ready_2cyc", int'(Ready), 1);
    check("inc0_dataiszero", int'(DataIsZero), 1);
    check("inc0_no_pulses", data_cnt, 5);

    run_cmd("left2b", CmdLeft, 4'd2);
    check("left2b_addr", int'(addr), 0);
    check("left2b_ap_pulses", ap_cnt, 10);
    check("left2b_dataiszero", int'(DataIsZero), 0);

    // Request strobed during GUARD/WAIT is ignored
    wait_ready("ignore");
    start_cmd(CmdInc, 4'd2);
    wait_pulse("ignore");
    @(negedge Clk);
    Request  = 1'b1;
    Insn     = CmdRight;
    RepCount = 4'd7;
    check("ignore_ready_low", int'(Ready), 0);
    @(negedge Clk);
    @(negedge Clk);
    Request = 1'b0;
    wait_ready("ignore");
    repeat (4) @(negedge Clk);
    check("ignore_data_pulses", data_cnt, 7);
    check("ignore_ap_pulses", ap_cnt, 10);
    check("ignore_cell", int'(mem[0]), 5);

    // LEFT at address 0
    run_cmd("leftbound", CmdLeft, 4'd1);
`ifdef AP_BOUND_CHECK_EN
    check("leftbound_ap_pulses", ap_cnt, 10);
    check("leftbound_fault", int'(Fault), 1);
    check("leftbound_addr", int'(addr), 0);
    run_cmd("faultclr", CmdNop, 4'd0);
    check("faultclr_fault", int'(Fault), 0);
`else
    check("leftbound_ap_pulses", ap_cnt, 11);
    check("leftbound_fault", int'(Fault), 0);
    check("leftbound_addr", int'(addr), 29999);
`endif

    check("never_both_requests", int'(both_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
